// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the multiplier dispatch front-end.
//   LEN_DEFAULT      default operand/result width (must match the multiplier)
//   mul_disp_state_t dispatch FSM state encoding {IDLE, WAIT}
`timescale 1ns/1ps
package mul_pkg;

  localparam int LEN_DEFAULT = 16;

  typedef enum logic {
    IDLE = 1'b0,  // looking at the FIFO head, may issue
    WAIT = 1'b1   // one product in flight, waiting for MUL_DONE
  } mul_disp_state_t;

endpackage

// File: rtl/mul_dispatch_if.sv
// mul_dispatch_if: bundles the producer, consumer and multiplier signals of
// mul_dispatch.
//   IN_VALID/IN_READY/IN_A/IN_B  operand-pair producer channel
//   OUT_VALID/OUT_READY/OUT_Y    result consumer channel
//   MUL_START/MUL_A/MUL_B        issue to the multiplier
//   MUL_DONE/MUL_Y               completion from the multiplier
// Handshake: a transfer happens on a rising CLK edge where VALID and READY
// are both high. A source holds VALID and its data stable until the
// transfer; READY may be high or low independently of VALID.
// modport slave is the dispatcher's view, master is the environment's view.
`timescale 1ns/1ps
interface mul_dispatch_if #(
  parameter int LEN = mul_pkg::LEN_DEFAULT
);
  logic           IN_VALID;
  logic           IN_READY;
  logic [LEN-1:0] IN_A;
  logic [LEN-1:0] IN_B;
  logic           OUT_VALID;
  logic           OUT_READY;
  logic [LEN-1:0] OUT_Y;
  logic           MUL_START;
  logic [LEN-1:0] MUL_A;
  logic [LEN-1:0] MUL_B;
  logic           MUL_DONE;
  logic [LEN-1:0] MUL_Y;

  modport slave (
    input  IN_VALID, IN_A, IN_B, OUT_READY, MUL_DONE, MUL_Y,
    output IN_READY, OUT_VALID, OUT_Y, MUL_START, MUL_A, MUL_B
  );

  modport master (
    output IN_VALID, IN_A, IN_B, OUT_READY, MUL_DONE, MUL_Y,
    input  IN_READY, OUT_VALID, OUT_Y, MUL_START, MUL_A, MUL_B
  );
endinterface

// File: rtl/mul_dispatch_fifo.sv
// mul_dispatch_fifo: DEPTH x W synchronous FIFO, synchronous active-high reset.
//   clk, rst      clock / reset
//   push, din     write when push & !full
//   pop           read when pop & !empty
//   dout          head entry (registered storage, read combinationally)
//   full, empty   status flags
// DEPTH must be a power of two >= 2.
`timescale 1ns/1ps
module mul_dispatch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         wr_en;
  logic         rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/mul_dispatch.sv
// mul_dispatch: front-end for the sequential radix-digit multiplier.
// Buffers operand pairs, issues them one at a time with a single-cycle
// MUL_START, and captures the LEN-bit truncated product into a one-entry
// result register. Issuing the next pair overlaps with a result waiting
// for OUT_READY.
//   CLK, RST   clock, synchronous active-high reset
//   bus        mul_dispatch_if.slave (producer, consumer, multiplier)
//   dbg_state  current FSM state
// Optional build macro: MUL_DISPATCH_ZERO_BYPASS_EN -- a head pair with a
// zero operand is answered with 0 directly from IDLE without issuing it.
`timescale 1ns/1ps
module mul_dispatch
  import mul_pkg::*;
#(
  parameter int LEN   = LEN_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic            CLK,
  input  logic            RST,
  mul_dispatch_if.slave   bus,
  output mul_disp_state_t dbg_state
);
  mul_disp_state_t state;
  mul_disp_state_t state_nxt;

  logic [2*LEN-1:0] head;
  logic [LEN-1:0]   head_a;
  logic [LEN-1:0]   head_b;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             slot_free;
  logic             capture;
  logic [LEN-1:0]   cap_y;
  logic             mul_start;
  logic             out_valid;
  logic [LEN-1:0]   out_y;

  assign push   = bus.IN_VALID && !full;
  assign head_a = head[2*LEN-1:LEN];
  assign head_b = head[LEN-1:0];

  mul_dispatch_fifo #(
    .W     (2*LEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .din   ({bus.IN_A, bus.IN_B}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // The result register can take a new value if it is empty or being
  // drained this very cycle.
  assign slot_free = !out_valid || bus.OUT_READY;

  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    pop       = 1'b0;
    capture   = 1'b0;
    cap_y     = bus.MUL_Y;
    unique case (state)
      IDLE: begin
        // MUL_DONE is deliberately not looked at here: it may be left over
        // from the previous product.
        if (!empty) begin
`ifdef MUL_DISPATCH_ZERO_BYPASS_EN
          if ((head_a == '0) || (head_b == '0)) begin
            if (slot_free) begin
              pop     = 1'b1;
              capture = 1'b1;
              cap_y   = '0;
            end
          end else begin
            mul_start = 1'b1;
            pop       = 1'b1;
            state_nxt = WAIT;
          end
`else
          mul_start = 1'b1;
          pop       = 1'b1;
          state_nxt = WAIT;
`endif
        end
      end
      WAIT: begin
        // The multiplier holds Y once done, so waiting for a free slot is safe.
        if (bus.MUL_DONE && slot_free) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_y     <= '0;
    end else begin
      state <= state_nxt;
      // A capture wins over a same-cycle drain, leaving the new value valid.
      if (capture) begin
        out_valid <= 1'b1;
        out_y     <= cap_y;
      end else if (bus.OUT_READY) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.IN_READY  = !full;
  assign bus.OUT_VALID = out_valid;
  assign bus.OUT_Y     = out_y;
  assign bus.MUL_START = mul_start;
  assign bus.MUL_A     = head_a;
  assign bus.MUL_B     = head_b;
  assign dbg_state     = state;
endmodule

// File: tb/tb_mul_dispatch.sv
// tb_mul_dispatch: directed bench for mul_dispatch paired with a behavioural
// model of the sequential multiplier (DONE two cycles after START for
// non-zero operands, one cycle for a zero operand; DONE and Y held until
// the next START; not reset).
`timescale 1ns/1ps
module tb_mul_dispatch;
  import mul_pkg::*;

  localparam int LEN = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_dispatch_if #(.LEN(LEN)) dif ();
  mul_disp_state_t dbg_state;

  mul_dispatch #(
    .LEN   (LEN),
    .DEPTH (4)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .bus       (dif.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- multiplier model ----------------
  logic [LEN-1:0] m_a    = '0;
  logic [LEN-1:0] m_b    = '0;
  logic [LEN-1:0] m_y    = '0;
  logic           m_done = 1'b0;
  int             m_cnt  = 0;

  assign dif.MUL_DONE = m_done;
  assign dif.MUL_Y    = m_y;

  always @(posedge clk) begin
    if (dif.MUL_START) begin
      if ((dif.MUL_A == '0) || (dif.MUL_B == '0)) begin
        m_done <= 1'b1;
        m_y    <= '0;
        m_cnt  <= 0;
      end else begin
        m_done <= 1'b0;
        m_a    <= dif.MUL_A;
        m_b    <= dif.MUL_B;
        m_cnt  <= 1;
      end
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_done <= 1'b1;
        m_y    <= m_a * m_b;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int cmp_cnt   = 0;
  int fail_cnt  = 0;
  int start_cnt = 0;
  logic [LEN-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && dif.OUT_VALID && dif.OUT_READY) begin
      check("result_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) check("result_value", {16'd0, dif.OUT_Y}, {16'd0, exp_q.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (!rst && dif.MUL_START) begin
      start_cnt++;
      check("start_in_idle", {31'd0, dbg_state == IDLE}, 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
    logic ok;
    ok = 1'b0;
    dif.IN_VALID = 1'b1;
    dif.IN_A     = a;
    dif.IN_B     = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = dif.IN_READY;
      @(posedge clk);
      #1;
    end
    dif.IN_VALID = 1'b0;
    check("push_accepted", {31'd0, ok}, 32'd1);
  endtask

  // Cycles from the cycle after acceptance (counted as 1) to OUT_VALID,
  // i.e. the IN_VALID -> OUT_VALID latency; 0 if it never came.
  task automatic wait_out(output int n);
    logic found;
    found = 1'b0;
    n = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      n++;
      found = dif.OUT_VALID;
    end
    if (!found) n = 0;
  endtask

  // ---------------- directed sequence ----------------
  int n;
  int s0;
  int exp_lat_zero;
  int exp_starts_zero;

  initial begin
`ifdef MUL_DISPATCH_ZERO_BYPASS_EN
    exp_lat_zero    = 2;
    exp_starts_zero = 0;
`else
    exp_lat_zero    = 3;
    exp_starts_zero = 1;
`endif
    dif.IN_VALID  = 1'b0;
    dif.IN_A      = '0;
    dif.IN_B      = '0;
    dif.OUT_READY = 1'b1;
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready",  {31'd0, dif.IN_READY},  32'd1);
    check("rst_out_valid", {31'd0, dif.OUT_VALID}, 32'd0);
    check("rst_out_y",     {16'd0, dif.OUT_Y},     32'd0);
    check("rst_mul_start", {31'd0, dif.MUL_START}, 32'd0);
    check("rst_state",     {31'd0, dbg_state == IDLE}, 32'd1);
    cycles(1);

    // Single op 3*5
    s0 = start_cnt;
    exp_q.push_back(16'd15);
    push(16'd3, 16'd5);
    wait_out(n);
    check("single_latency", n, 32'd4);
    cycles(3);
    check("single_starts", start_cnt - s0, 32'd1);
    @(negedge clk);
    check("single_drained", {31'd0, dif.OUT_VALID}, 32'd0);
    cycles(1);

    // Truncation 300*300 = 90000 mod 65536
    exp_q.push_back(16'd24464);
    push(16'd300, 16'd300);
    wait_out(n);
    check("trunc_latency", n, 32'd4);
    cycles(3);

    // Zero operand
    s0 = start_cnt;
    exp_q.push_back(16'd0);
    push(16'd0, 16'd1234);
    wait_out(n);
    check("zero_latency", n, exp_lat_zero);
    cycles(3);
    check("zero_starts", start_cnt - s0, exp_starts_zero);

    // Backpressure: 6 pairs with the consumer stalled
    dif.OUT_READY = 1'b0;
    for (int i = 1; i <= 6; i++) exp_q.push_back(LEN'(i * i));
    for (int i = 1; i <= 6; i++) push(LEN'(i), LEN'(i));
    @(negedge clk);
    check("bp_in_ready_low", {31'd0, dif.IN_READY},  32'd0);
    check("bp_out_valid",    {31'd0, dif.OUT_VALID}, 32'd1);
    check("bp_out_y",        {16'd0, dif.OUT_Y},     32'd1);
    cycles(4);
    @(negedge clk);
    check("bp_in_ready_held", {31'd0, dif.IN_READY}, 32'd0);
    check("bp_out_y_held",    {16'd0, dif.OUT_Y},    32'd1);
    cycles(1);
    dif.OUT_READY = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) cycles(1);
    check("bp_all_drained", exp_q.size(), 32'd0);
    cycles(2);
    @(negedge clk);
    check("bp_in_ready_back", {31'd0, dif.IN_READY},  32'd1);
    check("bp_out_valid_low", {31'd0, dif.OUT_VALID}, 32'd0);
    cycles(1);

    // Reset in the middle of a product
    push(16'hFFFF, 16'hFFFF);
    cycles(1);
    @(negedge clk);
    check("midrst_in_wait", {31'd0, dbg_state == WAIT}, 32'd1);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", {31'd0, dif.OUT_VALID}, 32'd0);
    check("midrst_state",     {31'd0, dbg_state == IDLE}, 32'd1);
    check("midrst_in_ready",  {31'd0, dif.IN_READY}, 32'd1);
    s0 = start_cnt;
    cycles(6);
    @(negedge clk);
    check("midrst_no_capture", {31'd0, dif.OUT_VALID}, 32'd0);
    check("midrst_fifo_empty", start_cnt - s0, 32'd0);
    cycles(1);
    exp_q.push_back(16'd63);
    push(16'd7, 16'd9);
    wait_out(n);
    check("after_rst_latency", n, 32'd4);
    cycles(3);

    // Stale DONE: leave the multiplier done with Y=15, then 2*0x1000
    exp_q.push_back(16'd15);
    push(16'd3, 16'd5);
    wait_out(n);
    check("stale_setup_latency", n, 32'd4);
    cycles(5);
    exp_q.push_back(16'h2000);
    push(16'd2, 16'h1000);
    wait_out(n);
    check("stale_latency", n, 32'd4);
    cycles(4);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end
endmodule
